// File: rtl/bit_serializer.sv
// bit_serializer
// Parallel-to-serial front end for the Mealy sequence detector. A WIDTH-bit
// word is accepted through a valid/ready load handshake and then presented
// one bit per consumed cycle. The bit order is LSB first by default, which
// matches the detector's seq[0]-first order. A one-cycle frame_done pulse
// follows the last bit of each word. Words can be streamed back to back.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over everything)
//   load_valid producer offers load_data this cycle
//   load_data  word to serialize
//   load_ready block can accept a word this cycle
//   ser_en     downstream consumes the current bit this cycle (0 = stall)
//   ser_bit    current serial bit (0 when not valid)
//   ser_valid  ser_bit is valid and consumed this cycle
//   frame_done registered one-cycle pulse after the last bit is consumed
//   busy       a word is being shifted out
module bit_serializer #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic last_bit;
    logic accept;

    // Last bit of the word is being consumed right now.
    assign last_bit   = (state == SHIFT) && ser_en && (cnt == LAST);
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    assign busy       = (state == SHIFT);
    assign ser_valid  = (state == SHIFT) && ser_en;
    assign ser_bit    = ser_valid ? (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]) : 1'b0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= load_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_en) begin
                        if (cnt == LAST) begin
                            frame_done <= 1'b1;
                            cnt        <= '0;
                            // A word offered in the last-bit cycle follows
                            // without an idle bubble.
                            if (accept) begin
                                shreg <= load_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            // Move the next bit toward the output end, zero fill.
                            if (LSB_FIRST) begin
                                shreg <= {1'b0, shreg[WIDTH-1:1]};
                            end else begin
                                shreg <= {shreg[WIDTH-2:0], 1'b0};
                            end
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 16-bit LSB-first instance
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = '0;
    logic        ser_en     = 1'b0;
    logic        load_ready, ser_bit, ser_valid, frame_done, busy;

    // 8-bit MSB-first instance
    logic        m_load_valid = 1'b0;
    logic [7:0]  m_load_data  = '0;
    logic        m_ser_en     = 1'b0;
    logic        m_load_ready, m_ser_bit, m_ser_valid, m_frame_done, m_busy;

    int checks = 0;
    int errors = 0;

    // Expected streams, written in emission order (index 0 = first bit out).
    logic [0:15] exp_base = 16'b0100_1110_1110_1010;                         // 16'h5772
    logic [0:31] exp_b2b  = 32'b1010_0101_1010_0101_1111_1111_0000_0000;    // A5A5, 00FF
    logic [0:15] exp_1234 = 16'b0010_1100_0100_1000;                         // 16'h1234
    logic [0:7]  exp_msb  = 8'b1011_0100;                                    // 8'hB4 MSB first

    bit_serializer #(.WIDTH(16), .LSB_FIRST(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_en     (ser_en),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load_valid (m_load_valid),
        .load_data  (m_load_data),
        .load_ready (m_load_ready),
        .ser_en     (m_ser_en),
        .ser_bit    (m_ser_bit),
        .ser_valid  (m_ser_valid),
        .frame_done (m_frame_done),
        .busy       (m_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the 16-bit instance for one cycle; outputs are settled 1 time
    // unit later, well before the next rising edge.
    task automatic drive(input logic r, input logic lv, input logic [15:0] ld, input logic en);
        @(negedge clk);
        rst        = r;
        load_valid = lv;
        load_data  = ld;
        ser_en     = en;
        #1;
    endtask

    task automatic check_bit(input string tag, input int idx, input logic exp);
        check($sformatf("%s_valid[%0d]", tag, idx), ser_valid, 1'b1);
        check($sformatf("%s_bit[%0d]", tag, idx), ser_bit, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_ser_valid",  ser_valid,  1'b0);
        check("rst_ser_bit",    ser_bit,    1'b0);
        check("rst_busy",       busy,       1'b0);
        check("rst_frame_done", frame_done, 1'b0);

        // ---------------- baseline ----------------
        drive(1'b0, 1'b1, 16'h5772, 1'b1);
        check("base_load_ready_idle", load_ready, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1);
            check_bit("base", i, exp_base[i]);
            check($sformatf("base_load_ready[%0d]", i), load_ready, (i == 15));
            check($sformatf("base_frame_done[%0d]", i), frame_done, 1'b0);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("base_frame_done",    frame_done, 1'b1);
        check("base_end_valid",     ser_valid,  1'b0);
        check("base_end_load_ready", load_ready, 1'b1);
        check("base_end_busy",      busy,       1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("base_frame_done_once", frame_done, 1'b0);

        // ---------------- stall on frame cycles 3..5 ----------------
        drive(1'b0, 1'b1, 16'h5772, 1'b1);
        begin
            int k = 0;
            for (int c = 1; c <= 19; c++) begin
                logic en;
                en = !(c >= 3 && c <= 5);
                drive(1'b0, 1'b0, 16'h0000, en);
                if (en) begin
                    check_bit("stall", k, exp_base[k]);
                    k++;
                end else begin
                    check($sformatf("stall_gap_valid[%0d]", c), ser_valid, 1'b0);
                    check($sformatf("stall_gap_bit[%0d]", c),   ser_bit,   1'b0);
                    check($sformatf("stall_gap_busy[%0d]", c),  busy,      1'b1);
                end
                check($sformatf("stall_frame_done[%0d]", c), frame_done, 1'b0);
            end
            check("stall_bit_count", k, 16);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("stall_frame_done", frame_done, 1'b1);
        check("stall_end_busy",   busy,       1'b0);

        // ---------------- back-to-back ----------------
        drive(1'b0, 1'b1, 16'hA5A5, 1'b1);
        for (int i = 0; i < 32; i++) begin
            if (i == 15) drive(1'b0, 1'b1, 16'h00FF, 1'b1);
            else         drive(1'b0, 1'b0, 16'h0000, 1'b1);
            check_bit("b2b", i, exp_b2b[i]);
            if (i == 15) check("b2b_load_ready_last", load_ready, 1'b1);
            check($sformatf("b2b_frame_done[%0d]", i), frame_done, (i == 16));
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("b2b_frame_done_2", frame_done, 1'b1);
        check("b2b_end_valid",    ser_valid,  1'b0);
        check("b2b_end_busy",     busy,       1'b0);

        // ---------------- load while busy is ignored ----------------
        drive(1'b0, 1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                drive(1'b0, 1'b1, 16'hFFFF, 1'b1);
                check("busy_load_ready", load_ready, 1'b0);
            end else begin
                drive(1'b0, 1'b0, 16'h0000, 1'b1);
            end
            check_bit("busy", i, exp_1234[i]);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("busy_frame_done", frame_done, 1'b1);
        check("busy_not_captured", busy, 1'b0);

        // ---------------- reset mid-frame ----------------
        drive(1'b0, 1'b1, 16'h5772, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1);
            check_bit("abort", i, exp_base[i]);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("abort_valid",      ser_valid,  1'b0);
        check("abort_busy",       busy,       1'b0);
        check("abort_load_ready", load_ready, 1'b1);
        check("abort_frame_done", frame_done, 1'b0);
        drive(1'b0, 1'b1, 16'h0001, 1'b1);
        check("abort_frame_done_2", frame_done, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1);
            check_bit("fresh", i, (i == 0));
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("fresh_frame_done", frame_done, 1'b1);

        // ---------------- rst and load_valid together ----------------
        drive(1'b1, 1'b1, 16'hFFFF, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rst_load_busy",  busy,      1'b0);
        check("rst_load_valid", ser_valid, 1'b0);

        // ---------------- MSB-first, WIDTH=8 ----------------
        @(negedge clk);
        m_load_valid = 1'b1;
        m_load_data  = 8'hB4;
        m_ser_en     = 1'b1;
        #1;
        check("msb_load_ready", m_load_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_load_valid = 1'b0;
            m_load_data  = 8'h00;
            #1;
            check($sformatf("msb_valid[%0d]", i), m_ser_valid, 1'b1);
            check($sformatf("msb_bit[%0d]", i),   m_ser_bit,   exp_msb[i]);
            check($sformatf("msb_frame_done[%0d]", i), m_frame_done, 1'b0);
        end
        @(negedge clk);
        #1;
        check("msb_frame_done", m_frame_done, 1'b1);
        check("msb_end_busy",   m_busy,       1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
